// File: rtl/mips_boot_pkg.sv
// Shared definitions for the MIPS boot loader: FSM states, header width,
// bytes-per-word constant and small state-decode helpers.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the CHK state).
package mips_boot_pkg;

    localparam int WORD_BYTES = 4;
    localparam int HDR_W      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
`ifdef BOOT_CHECKSUM_EN
        S_CHK,
`endif
        S_RELEASE,
        S_DONE,
        S_ERR
    } boot_state_e;

    // States in which the byte stream is being consumed
    function automatic logic st_rx(input boot_state_e s);
`ifdef BOOT_CHECKSUM_EN
        return (s == S_HDR) || (s == S_LOAD) || (s == S_CHK);
`else
        return (s == S_HDR) || (s == S_LOAD);
`endif
    endfunction

    // A session is in flight from header reception through CPU release
    function automatic logic st_busy(input boot_state_e s);
        return st_rx(s) || (s == S_RELEASE);
    endfunction

endpackage

// File: rtl/mips_boot_word_asm.sv
// Byte-to-word assembler: shifts accepted bytes in big-endian order and
// flags the cycle in which the 4th byte of a word is accepted.
module mips_boot_word_asm
    import mips_boot_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // Word completes when the last byte is on the input this cycle
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'(WORD_BYTES - 1));
    assign word_o       = {shift_q, byte_i};

    // Shift register and byte counter; counter wraps naturally every 4 bytes
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// MIPS boot loader: receives a length header and payload words over a byte
// stream, writes them to memory from BASE_ADDR, then releases the CPU.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing sum word is verified).
module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic                         boot_req,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic                         cpu_halt,
    output logic [31:0]                  cpu_pc,
    output logic                         cpu_release,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int              AW    = $clog2(MEM_DEPTH);
    localparam logic [HDR_W-1:0] MAX_N = HDR_W'(MEM_DEPTH - BASE_ADDR);

    boot_state_e      state_q, state_d;
    logic [HDR_W-1:0] n_q, idx_q;
    logic             rx_ready_q, mem_we_q, cpu_halt_q, cpu_release_q;
    logic             busy_q, done_q, err_q;
    logic [AW-1:0]    mem_addr_q;
    logic [31:0]      mem_wdata_q, cpu_pc_q;
    logic             accept, start, word_valid, hdr_ok, last_word;
    logic [31:0]      word;

    assign accept    = rx_valid && rx_ready_q;
    assign start     = boot_req && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign hdr_ok    = (word != '0) && (word <= MAX_N);
    assign last_word = (idx_q == n_q - 1'b1);

    mips_boot_word_asm u_asm (
        .clk1         (clk1),
        .rst          (rst),
        .clear_i      (start),
        .byte_valid_i (accept),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q;

    // Running mod-2^32 sum of payload words, restarted with each session
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)                                   sum_q <= '0;
        else if (start)                            sum_q <= '0;
        else if (state_q == S_LOAD && word_valid)  sum_q <= sum_q + word;
    end
`endif

    // Next-state selection; outputs are registered from this value below
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR;
            S_HDR:  if (word_valid) state_d = hdr_ok ? S_LOAD : S_ERR;
`ifdef BOOT_CHECKSUM_EN
            S_LOAD: if (word_valid && last_word) state_d = S_CHK;
            S_CHK:  if (word_valid) state_d = (word == sum_q) ? S_RELEASE : S_ERR;
`else
            S_LOAD: if (word_valid && last_word) state_d = S_RELEASE;
`endif
            S_RELEASE: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State, counters, memory write port and status outputs
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            idx_q         <= '0;
            rx_ready_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_halt_q    <= 1'b1;
            cpu_pc_q      <= '0;
            cpu_release_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_we_q <= 1'b0;
            if (start) begin
                n_q   <= '0;
                idx_q <= '0;
            end
            if (state_q == S_HDR && word_valid) n_q <= word;
            if (state_q == S_LOAD && word_valid) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= AW'(BASE_ADDR + idx_q);
                mem_wdata_q <= word;
                idx_q       <= idx_q + 1'b1;
            end
            rx_ready_q    <= st_rx(state_d);
            busy_q        <= st_busy(state_d);
            done_q        <= (state_d == S_DONE);
            err_q         <= (state_d == S_ERR);
            cpu_halt_q    <= !((state_d == S_RELEASE) || (state_d == S_DONE));
            cpu_release_q <= (state_d == S_RELEASE);
            if (state_d == S_RELEASE) cpu_pc_q <= 32'(BASE_ADDR);
        end
    end

    assign rx_ready    = rx_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_halt    = cpu_halt_q;
    assign cpu_pc      = cpu_pc_q;
    assign cpu_release = cpu_release_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Bench for mips_boot_loader: table of header cases plus hand sequences for
// reset abort, long randomized load with a stray boot_req, and checksum.
module tb_mips_boot_loader;

    localparam int MEM_DEPTH = 1024;
    localparam int BASE      = 0;

    logic        clk1, rst, boot_req, rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        mem_we, cpu_halt, cpu_release, busy, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, cpu_pc;

    mips_boot_loader #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE)) dut (
        .clk1(clk1), .rst(rst), .boot_req(boot_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_halt(cpu_halt), .cpu_pc(cpu_pc), .cpu_release(cpu_release),
        .busy(busy), .done(done), .err(err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t         wr_q[$];
    logic [31:0] pay_q[$];
    int          rel_cnt = 0;
    int          rel_bad = 0;

    typedef struct { logic [31:0] hdr; int gapmax; logic exp_err; } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Observe the memory write port and CPU release away from the active edge
    always @(negedge clk1) begin
        if (mem_we === 1'b1) wr_q.push_back('{int'(mem_addr), mem_wdata});
        if (cpu_release === 1'b1) begin
            rel_cnt++;
            if (cpu_halt !== 1'b0 || cpu_pc !== 32'(BASE)) rel_bad++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(posedge clk1); #1;
        boot_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin rx_valid = 1'b0; @(posedge clk1); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        @(negedge clk1);
        while (rx_ready !== 1'b1 && t < 50) begin @(negedge clk1); t++; end
        if (rx_ready !== 1'b1) begin
            chk("rx_ready_timeout", rx_ready, 1'b1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk1); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax, input bit boot_first);
        if (boot_first) boot_req = 1'b1;
        send_byte(w[31:24], boot_first ? 0 : $urandom_range(0, gapmax));
        boot_req = 1'b0;
        send_byte(w[23:16], $urandom_range(0, gapmax));
        send_byte(w[15:8],  $urandom_range(0, gapmax));
        send_byte(w[7:0],   $urandom_range(0, gapmax));
    endtask

    // One full session; expectations come from the header range rule and pay_q
    task automatic run_session(input logic [31:0] hdr, input int gapmax,
                               input bit bad_trl, input bit midboot, input string tag);
        bit          ok, fin_ok;
        logic [31:0] sum;
        int          t, nexp;
        ok     = (hdr >= 32'd1) && (hdr <= 32'(MEM_DEPTH - BASE));
        fin_ok = ok;
        sum    = '0;
        wr_q.delete();
        rel_cnt = 0;
        rel_bad = 0;
        pulse_boot();
        chk({tag, ".busy_start"}, busy, 1'b1);
        chk({tag, ".ready_start"}, rx_ready, 1'b1);
        send_word(hdr, gapmax, 1'b0);
        if (ok) begin
            foreach (pay_q[i]) begin
                send_word(pay_q[i], gapmax, midboot && (i == pay_q.size() / 2));
                sum += pay_q[i];
            end
`ifdef BOOT_CHECKSUM_EN
            send_word(bad_trl ? sum + 32'd1 : sum, gapmax, 1'b0);
            fin_ok = !bad_trl;
`endif
        end
        t = 0;
        while (!(done === 1'b1 || err === 1'b1) && t < 100) begin @(negedge clk1); t++; end
        chk({tag, ".finished"}, (done === 1'b1 || err === 1'b1), 1'b1);
        repeat (3) @(negedge clk1);
        nexp = ok ? pay_q.size() : 0;
        chk({tag, ".nwrites"}, wr_q.size(), nexp);
        for (int i = 0; i < nexp && i < wr_q.size(); i++) begin
            chk($sformatf("%s.addr[%0d]", tag, i), wr_q[i].addr, BASE + i);
            chk($sformatf("%s.data[%0d]", tag, i), wr_q[i].data, pay_q[i]);
        end
        chk({tag, ".done"}, done, fin_ok);
        chk({tag, ".err"}, err, !fin_ok);
        chk({tag, ".releases"}, rel_cnt, fin_ok ? 1 : 0);
        chk({tag, ".release_ctl"}, rel_bad, 0);
        chk({tag, ".halt"}, cpu_halt, !fin_ok);
        chk({tag, ".busy_end"}, busy, 1'b0);
        chk({tag, ".ready_end"}, rx_ready, 1'b0);
        if (fin_ok) chk({tag, ".pc"}, cpu_pc, 32'(BASE));
    endtask

    initial begin
        logic [31:0] w0, w1, w2;
        rst = 1'b1; boot_req = 1'b0; rx_valid = 1'b0; rx_data = '0;

        vecs[0] = '{hdr: 32'd0,          gapmax: 0, exp_err: 1'b1};
        vecs[1] = '{hdr: 32'h0000_0401,  gapmax: 1, exp_err: 1'b1};
        vecs[2] = '{hdr: 32'd1,          gapmax: 0, exp_err: 1'b0};
        vecs[3] = '{hdr: 32'd7,          gapmax: 3, exp_err: 1'b0};
        vecs[4] = '{hdr: 32'hFFFF_FFFF,  gapmax: 0, exp_err: 1'b1};
        vecs[5] = '{hdr: 32'd300,        gapmax: 1, exp_err: 1'b0};

        // Reset state
        repeat (2) @(posedge clk1); #1;
        chk("rst.halt", cpu_halt, 1'b1);
        chk("rst.pc", cpu_pc, 32'd0);
        chk("rst.release", cpu_release, 1'b0);
        chk("rst.we", mem_we, 1'b0);
        chk("rst.addr", mem_addr, 10'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        chk("rst.ready", rx_ready, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.err", err, 1'b0);
        rst = 1'b0;
        rx_valid = 1'b1;
        repeat (3) @(posedge clk1); #1;
        chk("idle.ready", rx_ready, 1'b0);
        chk("idle.busy", busy, 1'b0);
        rx_valid = 1'b0;

        // Basic two-word image
        pay_q.delete();
        pay_q.push_back(32'h2001_000A);
        pay_q.push_back(32'h2002_0014);
        run_session(32'd2, 0, 1'b0, 1'b0, "basic");

        // Header range table with random payloads
        foreach (vecs[k]) begin
            pay_q.delete();
            if (vecs[k].hdr >= 32'd1 && vecs[k].hdr <= 32'(MEM_DEPTH - BASE))
                for (int i = 0; i < int'(vecs[k].hdr); i++) pay_q.push_back($urandom);
            run_session(vecs[k].hdr, vecs[k].gapmax, 1'b0, 1'b0, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d.table_err", k), err, vecs[k].exp_err);
            repeat (4) @(negedge clk1);
            chk($sformatf("vec%0d.sticky", k), {done, err}, {!vecs[k].exp_err, vecs[k].exp_err});
        end

        // Reset abort just as the third word completes
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        wr_q.delete();
        pulse_boot();
        send_word(32'd3, 0, 1'b0);
        send_word(w0, 0, 1'b0);
        send_word(w1, 0, 1'b0);
        send_byte(w2[31:24], 0);
        send_byte(w2[23:16], 0);
        send_byte(w2[15:8], 0);
        rx_valid = 1'b1;
        rx_data  = w2[7:0];
        @(negedge clk1);
        rst = 1'b1;
        #1;
        chk("abort.halt", cpu_halt, 1'b1);
        chk("abort.busy", busy, 1'b0);
        chk("abort.ready", rx_ready, 1'b0);
        @(posedge clk1); #1;
        rx_valid = 1'b0;
        @(posedge clk1); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk1);
        chk("abort.nwrites", wr_q.size(), 2);
        chk("abort.done_err", {done, err}, 2'b00);
        pay_q.delete();
        pay_q.push_back(w0); pay_q.push_back(w1); pay_q.push_back(w2);
        run_session(32'd3, 1, 1'b0, 1'b0, "after_abort");

        // Full-depth image with random gaps and an ignored boot_req mid-load
        pay_q.delete();
        for (int i = 0; i < MEM_DEPTH - BASE; i++) pay_q.push_back($urandom);
        run_session(32'(MEM_DEPTH - BASE), 3, 1'b0, 1'b1, "full");
        if (wr_q.size() > 0) chk("full.last_addr", wr_q[wr_q.size() - 1].addr, MEM_DEPTH - 1);

`ifdef BOOT_CHECKSUM_EN
        // Sum wraps to zero; good and corrupted trailers
        pay_q.delete();
        pay_q.push_back(32'h0000_0001);
        pay_q.push_back(32'hFFFF_FFFF);
        run_session(32'd2, 0, 1'b0, 1'b0, "cks_good");
        run_session(32'd2, 0, 1'b1, 1'b0, "cks_bad");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_boot_loader.md
MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, shall set the number of 32-bit words in the target memory.
REQ-002 Parameter BASE_ADDR, default 0, shall set the first word address written and the PC value driven at release.
REQ-003 Port clk1, input, 1 bit: the single clock. All state shall update on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port boot_req, input, 1 bit: a single-cycle pulse that starts a load session.
REQ-006 Ports rx_data (input, 8), rx_valid (input, 1) and rx_ready (output, 1) shall form the byte-stream handshake; a byte transfers only in a cycle where rx_valid && rx_ready.
REQ-007 Ports mem_we (output, 1), mem_addr (output, $clog2(MEM_DEPTH)) and mem_wdata (output, 32) shall form the instruction/data memory write port.
REQ-008 Ports cpu_halt (output, 1), cpu_pc (output, 32) and cpu_release (output, 1) shall form the CPU control interface.
REQ-009 Ports busy (output, 1), done (output, 1) and err (output, 1) shall report session status.

Function
REQ-010 The FSM states shall be IDLE, HDR, LOAD, CHK, RELEASE, DONE and ERR.
REQ-011 IDLE: rx_ready shall be 0; boot_req shall move the FSM to HDR and clear the byte counter, word counter and sum.
REQ-012 Each word shall be assembled big-endian from 4 accepted bytes, first byte into bits [31:24].
REQ-013 HDR: the first word shall be the payload count N; valid range is 1..MEM_DEPTH-BASE_ADDR.
REQ-014 HDR: an out-of-range N shall move the FSM to ERR; an in-range N shall move it to LOAD.
REQ-015 LOAD: on the cycle after each 4th accepted byte, mem_we shall be 1 for exactly one cycle, with mem_addr = BASE_ADDR + word index and mem_wdata = the assembled word.
REQ-016 LOAD: after word N-1 is written, the FSM shall go to CHK if BOOT_CHECKSUM_EN is defined, otherwise to RELEASE.
REQ-017 rx_ready shall be 1 in HDR, LOAD and CHK, and 0 in all other states; throughput shall be 1 byte per cycle with no back-pressure while loading.
REQ-018 Idle rx_valid cycles shall hold all partial state; no timeout applies.
REQ-019 RELEASE shall last one cycle: cpu_pc = BASE_ADDR, cpu_release = 1, cpu_halt -> 0, then the FSM goes to DONE.
REQ-020 cpu_halt shall be 1 in every state except RELEASE and DONE.
REQ-021 DONE and ERR are sticky; only boot_req (restarting from HDR) or rst shall leave them.
REQ-022 A boot_req while busy shall be ignored.
REQ-023 busy = (state is HDR, LOAD, CHK or RELEASE); done = (state is DONE); err = (state is ERR).
REQ-024 In ERR, mem_we shall remain 0 and cpu_halt shall remain 1.

Reset
REQ-025 rst shall set the state to IDLE, all counters and the sum to 0, and cpu_halt=1, cpu_pc=0, cpu_release=0, mem_we=0, mem_addr=0, mem_wdata=0, rx_ready=0, busy=0, done=0, err=0.
REQ-026 rst during LOAD shall abort the session immediately with no further mem_we pulse; already-written words are not restored.

Configuration
REQ-027 With BOOT_CHECKSUM_EN defined, a 32-bit sum (mod 2^32) of all payload words shall be accumulated, and one trailing word shall be received in CHK.
REQ-028 With BOOT_CHECKSUM_EN defined, a trailing word equal to the sum shall move the FSM to RELEASE; a mismatch shall move it to ERR.
REQ-029 Without BOOT_CHECKSUM_EN, no sum logic or CHK state shall exist, and LOAD shall go directly to RELEASE.

Structure
REQ-030 A shared package mips_boot_pkg shall hold the state enum, the header field width and the WORD_BYTES=4 constant.
REQ-031 One sub-module, mips_boot_word_asm, shall implement the byte-to-word assembler: byte shift register, 2-bit byte counter and word_valid pulse.

Verification
REQ-032 boot_req; bytes 00 00 00 02, 20 01 00 0A, 20 02 00 14 -> mem[0]=0x2001000A, mem[1]=0x20020014, cpu_release pulse, cpu_pc=0, done=1.
REQ-033 Header 0x00000000, and separately header 0x00000401 with MEM_DEPTH=1024 -> err=1, zero mem_we pulses, cpu_halt=1.
REQ-034 BOOT_CHECKSUM_EN defined, payload 0x00000001 and 0xFFFFFFFF, trailer 0x00000000 -> done=1; same payload with trailer 0x00000001 -> err=1, no release.
REQ-035 rst asserted after 2 of 3 payload words -> state IDLE, cpu_halt=1 in the same cycle, no third mem_we pulse; a new boot_req then loads correctly.
REQ-036 Random rx_valid gaps, 1024-word payload -> 1024 mem_we pulses, last at mem_addr=1023, data matches stimulus, and a boot_req mid-load is ignored.
